// File: rtl/mod100_pkg.sv
// Shared constants and types for the mod-100 counter and its BCD digit counters.
package mod100_pkg;

  localparam int unsigned MOD100_MODULUS = 100;
  localparam int unsigned MOD100_CNT_W   = 7;
  localparam int unsigned BCD_DIGIT_W    = 4;
  localparam int unsigned BCD_DIGIT_MAX  = 9;

  typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

endpackage

// File: rtl/bcd_digit_counter.sv
// Single mod-10 BCD digit: advances on carry_i, raises carry_c_o combinationally
// on the 9 -> 0 rollover. Async active-high reset.
module bcd_digit_counter
  import mod100_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   carry_i,
  output logic [BCD_DIGIT_W-1:0] digit_o,
  output logic                   carry_c_o
);

  bcd_digit_t digit_q;
  bcd_digit_t digit_d;
  logic       at_max;

  // Values above 9 are unreachable; treating them as max forces a return to 0.
  assign at_max = (digit_q >= bcd_digit_t'(BCD_DIGIT_MAX));

  always_comb begin
    digit_d = digit_q;
    if (carry_i) begin
      digit_d = at_max ? bcd_digit_t'(0) : digit_q + bcd_digit_t'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit_o   = digit_q;
  assign carry_c_o = carry_i & at_max;

endmodule

// File: rtl/mod_100_counter.sv
// Free-running 0..MODULUS-1 counter with registered terminal-count flag.
// Optional two-digit BCD view built when MOD100_BCD_EN is defined.
module mod_100_counter
  import mod100_pkg::*;
#(
  parameter int unsigned MODULUS = MOD100_MODULUS,
  parameter int unsigned CNT_W   = MOD100_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] count,
  output logic             tc
`ifdef MOD100_BCD_EN
  ,
  output logic [BCD_DIGIT_W-1:0] bcd_tens,
  output logic [BCD_DIGIT_W-1:0] bcd_units
`endif
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MODULUS - 1);

  if ((2 ** CNT_W) < MODULUS) begin : g_bad_width
    $error("CNT_W too narrow for MODULUS");
  end

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             tc_q;
  logic             tc_d;
  logic             wrap;

`ifdef MOD100_BCD_EN
  if (MODULUS != 100) begin : g_bad_modulus
    $error("BCD view only supports MODULUS == 100");
  end

  logic       units_carry;
  logic       tens_carry;
  bcd_digit_t units_digit;
  bcd_digit_t tens_digit;

  bcd_digit_counter u_units (
    .clk       (clk),
    .rst       (rst),
    .carry_i   (1'b1),
    .digit_o   (units_digit),
    .carry_c_o (units_carry)
  );

  bcd_digit_counter u_tens (
    .clk       (clk),
    .rst       (rst),
    .carry_i   (units_carry),
    .digit_o   (tens_digit),
    .carry_c_o (tens_carry)
  );

  // A 99 -> 00 digit rollover also forces the binary wrap, keeping both views aligned.
  assign wrap = (count_q >= CNT_LAST) | tens_carry;

  assign bcd_tens  = tens_digit;
  assign bcd_units = units_digit;
`else
  assign wrap = (count_q >= CNT_LAST);
`endif

  // tc is decoded from the next count so it comes straight off a flop, glitch-free.
  always_comb begin
    count_d = wrap ? '0 : count_q + CNT_W'(1);
    tc_d    = (count_d == CNT_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;

endmodule

// File: tb/tb_mod_100_counter.sv
// Self-checking bench for mod_100_counter: cycle-count reference model plus
// directed literal checks and randomized asynchronous reset pulses.
module tb_mod_100_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] count;
  logic       tc;
`ifdef MOD100_BCD_EN
  logic [3:0] bcd_tens;
  logic [3:0] bcd_units;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  mod_100_counter dut (
    .clk   (clk),
    .rst   (rst),
    .count (count),
    .tc    (tc)
`ifdef MOD100_BCD_EN
    ,
    .bcd_tens  (bcd_tens),
    .bcd_units (bcd_units)
`endif
  );

  always #5 clk = ~clk;

  // Reference: number of clock edges since reset release, taken modulo 100.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_count", int'(count), cyc % 100);
      chk("model_tc", int'(tc), (cyc % 100 == 99) ? 1 : 0);
`ifdef MOD100_BCD_EN
      chk("model_tens", int'(bcd_tens), (cyc % 100) / 10);
      chk("model_units", int'(bcd_units), cyc % 10);
      chk("bcd_invariant", 10 * int'(bcd_tens) + int'(bcd_units), int'(count));
`endif
    end
  end

  task automatic wait_count(input int target);
    int n;
    n = 0;
    while (int'(count) != target && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("reach_count", int'(count), target);
  endtask

  task automatic release_rst;
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    int pulses, first_i, last_i, max_cnt, n, hold;

    // Reset hold.
    #1 rst = 1'b1;
    chk_en = 1'b1;
    #1;
    chk("rst_count", int'(count), 0);
    chk("rst_tc", int'(tc), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hold_count", int'(count), 0);
`ifdef MOD100_BCD_EN
    chk("rst_hold_bcd", {24'd0, bcd_tens, bcd_units}, 0);
`endif
    release_rst();
    @(posedge clk);
    #1 chk("release_first", int'(count), 1);

    // Wrap continuity over 250 samples.
    pulses = 0; first_i = -1; last_i = -1; max_cnt = 0;
    for (int i = 0; i < 250; i++) begin
      @(negedge clk);
      if (tc) begin
        pulses++;
        if (first_i < 0) first_i = i;
        last_i = i;
      end
      if (int'(count) > max_cnt) max_cnt = int'(count);
    end
    chk("tc_pulses", pulses, 2);
    chk("tc_spacing", last_i - first_i, 100);
    chk("max_count", max_cnt, 99);

    // Async reset mid-run at count 37.
    wait_count(37);
    #2 rst = 1'b1;
    #1;
    chk("async_count", int'(count), 0);
    chk("async_tc", int'(tc), 0);
`ifdef MOD100_BCD_EN
    chk("async_bcd", {24'd0, bcd_tens, bcd_units}, 0);
`endif
    @(posedge clk);
    release_rst();
    @(posedge clk);
    #1 chk("resume_1", int'(count), 1);
    @(posedge clk);
    #1 chk("resume_2", int'(count), 2);

    // Digit boundaries.
    wait_count(59);
`ifdef MOD100_BCD_EN
    chk("bcd59", {24'd0, bcd_tens, bcd_units}, 8'h59);
`endif
    @(posedge clk);
    #1 chk("count60", int'(count), 60);
`ifdef MOD100_BCD_EN
    chk("bcd60", {24'd0, bcd_tens, bcd_units}, 8'h60);
`endif
    wait_count(99);
    chk("tc_at_99", int'(tc), 1);
`ifdef MOD100_BCD_EN
    chk("bcd99", {24'd0, bcd_tens, bcd_units}, 8'h99);
`endif
    @(posedge clk);
    #1 chk("wrap_count", int'(count), 0);
    chk("wrap_tc", int'(tc), 0);
`ifdef MOD100_BCD_EN
    chk("bcd00", {24'd0, bcd_tens, bcd_units}, 0);
`endif

    // Randomized run lengths with asynchronous reset pulses.
    for (int k = 0; k < 12; k++) begin
      n = $urandom_range(1, 250);
      repeat (n) @(negedge clk);
      #($urandom_range(1, 3)) rst = 1'b1;
      #1 chk("rand_rst_count", int'(count), 0);
      hold = $urandom_range(1, 3);
      repeat (hold) @(posedge clk);
      release_rst();
    end
    repeat (120) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
